// File: rtl/riscv_boot_loader.sv
// riscv_boot_loader
//   Receives a program image as a byte stream and writes it as 32-bit words
//   into the instruction memory write port. The CPU core is held in reset
//   until the image is loaded, then released.
//   Image format: 16-bit little-endian word count N, then N little-endian words.
//
// Ports
//   clk_150_mhz  system clock, all state on the rising edge
//   rst_n        asynchronous active-low reset
//   rx_valid     rx_data holds a valid byte
//   rx_data      image byte
//   rx_ready     loader accepts a byte this cycle
//   reload       one-cycle pulse, restarts the load from RUN or ERROR
//   imem_we      instruction memory write strobe (one cycle per word)
//   imem_addr    word address of the write
//   imem_wdata   write data
//   cpu_rst_n    active-low reset to the CPU core
//   boot_done    image loaded, core running
//   boot_err     word count exceeds the memory depth
module riscv_boot_loader #(
  parameter int IMEM_ADDR_W   = 8,
  parameter int RELEASE_DELAY = 4
) (
  input  logic                   clk_150_mhz,
  input  logic                   rst_n,
  input  logic                   rx_valid,
  input  logic [7:0]             rx_data,
  output logic                   rx_ready,
  input  logic                   reload,
  output logic                   imem_we,
  output logic [IMEM_ADDR_W-1:0] imem_addr,
  output logic [31:0]            imem_wdata,
  output logic                   cpu_rst_n,
  output logic                   boot_done,
  output logic                   boot_err
);

  localparam int                 HOLD_W    = $clog2(RELEASE_DELAY + 1);
  localparam logic [16:0]        MEM_DEPTH = 17'(1) << IMEM_ADDR_W;
  localparam logic [HOLD_W-1:0]  HOLD_LAST = HOLD_W'(RELEASE_DELAY - 1);
  localparam logic [HOLD_W-1:0]  HOLD_ONE  = HOLD_W'(1);
  localparam logic [IMEM_ADDR_W:0] WIDX_ONE = (IMEM_ADDR_W + 1)'(1);

  typedef enum logic [2:0] {
    S_HDR0,
    S_HDR1,
    S_DATA,
    S_HOLD,
    S_RUN,
    S_ERROR
  } state_e;

  state_e                 state_q;
  logic [15:0]            nCount_q;
  logic [1:0]             byteIdx_q;
  logic [23:0]            wordBuf_q;
  logic [IMEM_ADDR_W:0]   wordIdx_q;
  logic [HOLD_W-1:0]      holdCnt_q;
  logic                   imemWe_q;
  logic [IMEM_ADDR_W-1:0] imemAddr_q;
  logic [31:0]            imemWdata_q;
  logic                   cpuRstN_q;
  logic                   bootDone_q;
  logic                   bootErr_q;

  logic        xfer;
  logic [16:0] hdrCount;
  logic        lastWord;

  // rx_ready is a pure state decode, forced low while reset is asserted so
  // the upstream source sees no acceptance during reset.
  assign rx_ready = rst_n && ((state_q == S_HDR0) || (state_q == S_HDR1) ||
                              (state_q == S_DATA));
  assign xfer     = rx_valid && rx_ready;

  // Full word count as it becomes known on the second header byte; widened
  // so that a count equal to the memory depth compares correctly.
  assign hdrCount = {1'b0, rx_data, nCount_q[7:0]};

  // The word being completed is the final one of the image.
  assign lastWord = ((17'(wordIdx_q) + 17'd1) == {1'b0, nCount_q});

  always_ff @(posedge clk_150_mhz or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_HDR0;
      nCount_q    <= '0;
      byteIdx_q   <= '0;
      wordBuf_q   <= '0;
      wordIdx_q   <= '0;
      holdCnt_q   <= '0;
      imemWe_q    <= 1'b0;
      imemAddr_q  <= '0;
      imemWdata_q <= '0;
      cpuRstN_q   <= 1'b0;
      bootDone_q  <= 1'b0;
      bootErr_q   <= 1'b0;
    end else begin
      // The write strobe is a single-cycle pulse after each completed word.
      imemWe_q <= 1'b0;
      case (state_q)
        S_HDR0: begin
          if (xfer) begin
            nCount_q[7:0] <= rx_data;
            state_q       <= S_HDR1;
          end
        end
        S_HDR1: begin
          if (xfer) begin
            nCount_q[15:8] <= rx_data;
            byteIdx_q      <= '0;
            wordIdx_q      <= '0;
            holdCnt_q      <= '0;
            if (hdrCount > MEM_DEPTH) begin
              bootErr_q <= 1'b1;
              state_q   <= S_ERROR;
            end else if (hdrCount == 17'd0) begin
              state_q <= S_HOLD;
            end else begin
              state_q <= S_DATA;
            end
          end
        end
        S_DATA: begin
          // Byte k of a word lands in bits [8k+7:8k]; the fourth byte is
          // merged directly into the write data without being buffered.
          if (xfer) begin
            byteIdx_q <= byteIdx_q + 2'd1;
            case (byteIdx_q)
              2'd0: wordBuf_q[7:0]   <= rx_data;
              2'd1: wordBuf_q[15:8]  <= rx_data;
              2'd2: wordBuf_q[23:16] <= rx_data;
              default: begin
                imemWdata_q <= {rx_data, wordBuf_q};
                imemAddr_q  <= wordIdx_q[IMEM_ADDR_W-1:0];
                imemWe_q    <= 1'b1;
                wordIdx_q   <= wordIdx_q + WIDX_ONE;
                if (lastWord) begin
                  holdCnt_q <= '0;
                  state_q   <= S_HOLD;
                end
              end
            endcase
          end
        end
        S_HOLD: begin
          // The counter starts at zero on the entry edge, so the release
          // lands exactly RELEASE_DELAY edges after the final image byte.
          if (holdCnt_q == HOLD_LAST) begin
            cpuRstN_q  <= 1'b1;
            bootDone_q <= 1'b1;
            state_q    <= S_RUN;
          end else begin
            holdCnt_q <= holdCnt_q + HOLD_ONE;
          end
        end
        S_RUN, S_ERROR: begin
          if (reload) begin
            cpuRstN_q  <= 1'b0;
            bootDone_q <= 1'b0;
            bootErr_q  <= 1'b0;
            wordIdx_q  <= '0;
            byteIdx_q  <= '0;
            state_q    <= S_HDR0;
          end
        end
        default: state_q <= S_HDR0;
      endcase
    end
  end

  assign imem_we    = imemWe_q;
  assign imem_addr  = imemAddr_q;
  assign imem_wdata = imemWdata_q;
  assign cpu_rst_n  = cpuRstN_q;
  assign boot_done  = bootDone_q;
  assign boot_err   = bootErr_q;

endmodule

// File: tb/tb_riscv_boot_loader.sv
`timescale 1ns/1ps
// Testbench for riscv_boot_loader: drives byte images with optional random
// rx_valid gaps and compares captured memory writes and core release timing
// against a reference computed directly from the image bytes.
module tb_riscv_boot_loader;

  localparam int AW = 8;
  localparam int RD = 4;

  logic          clk      = 1'b0;
  logic          rst_n    = 1'b1;
  logic          rx_valid = 1'b0;
  logic [7:0]    rx_data  = 8'h00;
  logic          reload   = 1'b0;
  logic          rx_ready;
  logic          imem_we;
  logic [AW-1:0] imem_addr;
  logic [31:0]   imem_wdata;
  logic          cpu_rst_n;
  logic          boot_done;
  logic          boot_err;

  riscv_boot_loader #(
    .IMEM_ADDR_W  (AW),
    .RELEASE_DELAY(RD)
  ) dut (
    .clk_150_mhz(clk),
    .rst_n      (rst_n),
    .rx_valid   (rx_valid),
    .rx_data    (rx_data),
    .rx_ready   (rx_ready),
    .reload     (reload),
    .imem_we    (imem_we),
    .imem_addr  (imem_addr),
    .imem_wdata (imem_wdata),
    .cpu_rst_n  (cpu_rst_n),
    .boot_done  (boot_done),
    .boot_err   (boot_err)
  );

  always #3 clk = ~clk;

  int vectors     = 0;
  int miscompares = 0;
  int cycleCnt    = 0;
  int lastEdge    = 0;
  int relEdge     = -1;
  int rises       = 0;
  logic prevCpu   = 1'b0;

  logic [7:0]    img[$];
  logic [AW-1:0] gotAddr[$];
  logic [31:0]   gotData[$];

  // Count rising edges so transfer and release times can be compared.
  always @(posedge clk) cycleCnt++;

  // Observe outputs on the falling edge, half a cycle away from updates.
  always @(negedge clk) begin
    if (imem_we) begin
      gotAddr.push_back(imem_addr);
      gotData.push_back(imem_wdata);
    end
    if (cpu_rst_n && !prevCpu) begin
      relEdge = cycleCnt;
      rises++;
    end
    prevCpu = cpu_rst_n;
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs,
                             input logic [31:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic clearMonitor();
    gotAddr.delete();
    gotData.delete();
    relEdge = -1;
    rises   = 0;
  endtask

  task automatic doReset();
    @(negedge clk);
    rst_n    = 1'b0;
    rx_valid = 1'b0;
    reload   = 1'b0;
    repeat (2) @(negedge clk);
    clearMonitor();
    rst_n = 1'b1;
  endtask

  // Send img[first..last-1]; pct is the percentage of cycles rx_valid is high.
  task automatic applyStimulus(input int first, input int last, input int pct);
    bit accepted;
    int tries;
    for (int i = first; i < last; i++) begin
      accepted = 1'b0;
      tries    = 0;
      while (!accepted) begin
        @(negedge clk);
        if (int'($urandom_range(99)) < pct) begin
          rx_valid = 1'b1;
          rx_data  = img[i];
        end else begin
          rx_valid = 1'b0;
          rx_data  = 8'($urandom);
        end
        if (rx_valid && rx_ready) begin
          accepted = 1'b1;
          lastEdge = cycleCnt + 1;
        end
        tries++;
        if (!accepted && tries > 1000) begin
          rx_valid = 1'b0;
          checkOutput("rx_ready_timeout", 32'(rx_ready), 32'd1);
          return;
        end
      end
    end
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  task automatic waitRelease();
    for (int i = 0; i < 50 && !cpu_rst_n; i++) @(negedge clk);
    repeat (3) @(negedge clk);
  endtask

  task automatic buildRandom(input int n);
    img.delete();
    img.push_back(n[7:0]);
    img.push_back(n[15:8]);
    for (int i = 0; i < 4 * n; i++) img.push_back(8'($urandom));
  endtask

  // Reference: word i is the little-endian value of image bytes 2+4i..5+4i,
  // written to address i; the core is released RD edges after the last byte.
  task automatic modelCheck(input string tag);
    int n;
    longint w;
    n = int'(img[0]) + 256 * int'(img[1]);
    checkOutput({tag, "_nwrites"}, 32'(gotAddr.size()), 32'(n));
    for (int i = 0; i < n && i < gotAddr.size(); i++) begin
      w = 0;
      for (int k = 3; k >= 0; k--) w = w * 256 + longint'(img[2 + 4 * i + k]);
      checkOutput($sformatf("%s_addr%0d", tag, i), 32'(gotAddr[i]), 32'(i % 256));
      checkOutput($sformatf("%s_data%0d", tag, i), gotData[i], 32'(w));
    end
    checkOutput({tag, "_release_delay"}, 32'(relEdge - lastEdge), 32'(RD));
    checkOutput({tag, "_cpu_rst_n"}, 32'(cpu_rst_n), 32'd1);
    checkOutput({tag, "_boot_done"}, 32'(boot_done), 32'd1);
    checkOutput({tag, "_boot_err"}, 32'(boot_err), 32'd0);
    checkOutput({tag, "_rx_ready"}, 32'(rx_ready), 32'd0);
  endtask

  task automatic checkAllReset(input string tag);
    checkOutput({tag, "_rx_ready"}, 32'(rx_ready), 32'd0);
    checkOutput({tag, "_imem_we"}, 32'(imem_we), 32'd0);
    checkOutput({tag, "_imem_addr"}, 32'(imem_addr), 32'd0);
    checkOutput({tag, "_imem_wdata"}, imem_wdata, 32'd0);
    checkOutput({tag, "_cpu_rst_n"}, 32'(cpu_rst_n), 32'd0);
    checkOutput({tag, "_boot_done"}, 32'(boot_done), 32'd0);
    checkOutput({tag, "_boot_err"}, 32'(boot_err), 32'd0);
  endtask

  initial begin
    $display("[TB] riscv_boot_loader bench starting");

    // Reset values while rst_n is held low.
    #1 rst_n = 1'b0;
    #1 checkAllReset("reset");
    repeat (2) @(negedge clk);
    clearMonitor();
    rst_n = 1'b1;
    #1 checkOutput("hdr0_rx_ready", 32'(rx_ready), 32'd1);

    // Reference two-word image, back to back.
    $display("[TB] two-word image, back to back");
    img = '{8'h02, 8'h00, 8'h13, 8'h00, 8'h10, 8'h00, 8'h93, 8'h00, 8'h20, 8'h00};
    applyStimulus(0, 10, 100);
    waitRelease();
    modelCheck("basic");
    if (gotData.size() >= 2) begin
      checkOutput("basic_word0", gotData[0], 32'h00100013);
      checkOutput("basic_word1", gotData[1], 32'h00200093);
    end

    // Same image with rx_valid dropping about half the time.
    $display("[TB] two-word image, gappy rx_valid");
    doReset();
    applyStimulus(0, 10, 50);
    waitRelease();
    modelCheck("gappy");

    // Empty image goes straight to hold.
    $display("[TB] empty image");
    doReset();
    img = '{8'h00, 8'h00};
    applyStimulus(0, 2, 100);
    waitRelease();
    modelCheck("empty");

    // Oversized word count locks into error.
    $display("[TB] oversized image");
    doReset();
    img = '{8'h01, 8'h01};
    applyStimulus(0, 2, 100);
    checkOutput("err_boot_err", 32'(boot_err), 32'd1);
    checkOutput("err_rx_ready", 32'(rx_ready), 32'd0);
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      rx_valid = 1'($urandom);
      rx_data  = 8'($urandom);
    end
    rx_valid = 1'b0;
    checkOutput("err_rises", 32'(rises), 32'd0);
    checkOutput("err_cpu_rst_n", 32'(cpu_rst_n), 32'd0);
    checkOutput("err_nwrites", 32'(gotAddr.size()), 32'd0);
    checkOutput("err_boot_err_held", 32'(boot_err), 32'd1);

    // Reload out of error, then fill the whole memory.
    $display("[TB] reload from error, full-depth image");
    @(negedge clk);
    reload = 1'b1;
    @(negedge clk);
    reload = 1'b0;
    checkOutput("err_reload_boot_err", 32'(boot_err), 32'd0);
    checkOutput("err_reload_rx_ready", 32'(rx_ready), 32'd1);
    clearMonitor();
    buildRandom(256);
    applyStimulus(0, img.size(), 100);
    waitRelease();
    modelCheck("full");
    if (gotAddr.size() > 0)
      checkOutput("full_last_addr", 32'(gotAddr[gotAddr.size() - 1]), 32'hFF);

    // Random images with random gap densities.
    for (int t = 0; t < 3; t++) begin
      doReset();
      buildRandom(1 + int'($urandom_range(15)));
      applyStimulus(0, img.size(), 30 + int'($urandom_range(70)));
      waitRelease();
      modelCheck($sformatf("rand%0d", t));
    end

    // Reset in the middle of the data phase, then reload the full image.
    $display("[TB] reset mid-load");
    doReset();
    img = '{8'h02, 8'h00, 8'h13, 8'h00, 8'h10, 8'h00, 8'h93, 8'h00, 8'h20, 8'h00};
    applyStimulus(0, 8, 100);
    #1 rst_n = 1'b0;
    #1 checkAllReset("midrst");
    @(negedge clk);
    @(negedge clk);
    clearMonitor();
    rst_n = 1'b1;
    applyStimulus(0, 10, 100);
    waitRelease();
    modelCheck("after_rst");

    // Reload from RUN; a reload pulse during DATA must be ignored.
    $display("[TB] reload from run");
    @(negedge clk);
    reload = 1'b1;
    @(negedge clk);
    reload = 1'b0;
    checkOutput("run_reload_cpu_rst_n", 32'(cpu_rst_n), 32'd0);
    checkOutput("run_reload_boot_done", 32'(boot_done), 32'd0);
    clearMonitor();
    img = '{8'h01, 8'h00, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
    applyStimulus(0, 4, 100);
    @(negedge clk);
    reload = 1'b1;
    @(negedge clk);
    reload = 1'b0;
    checkOutput("data_reload_rx_ready", 32'(rx_ready), 32'd1);
    applyStimulus(4, 6, 100);
    waitRelease();
    modelCheck("reload");
    if (gotData.size() >= 1)
      checkOutput("reload_word0", gotData[0], 32'hDEADBEEF);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
